// File: rtl/contador_pkg.sv
// Shared definitions for the parametrised counter: MODO encodings and reset value.
package contador_pkg;

    localparam logic [2:0] MODO_UP        = 3'b000;
    localparam logic [2:0] MODO_DOWN      = 3'b001;
    localparam logic [2:0] MODO_DOWN_STEP = 3'b010;
    localparam logic [2:0] MODO_LOAD      = 3'b011;
    localparam logic [2:0] MODO_UP_STEP   = 3'b100;
    localparam logic [2:0] MODO_MOD       = 3'b101;

    localparam int unsigned RESET_VALUE = 0;

endpackage

// File: rtl/contador_paso.sv
// Combinational next count and wrap flag for the current value, mode and limit.
module contador_paso
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STEP  = 3
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       modo_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    // Extra MSB holds the carry (up modes) or borrow (down modes).
    logic [WIDTH:0] sum;

    always_comb begin
        sum    = '0;
        next_o = q_i;
        wrap_o = 1'b0;
        case (modo_i)
            MODO_UP: begin
                sum    = {1'b0, q_i} + {{WIDTH{1'b0}}, 1'b1};
                next_o = sum[WIDTH-1:0];
                wrap_o = sum[WIDTH];
            end
            MODO_DOWN: begin
                sum    = {1'b0, q_i} - {{WIDTH{1'b0}}, 1'b1};
                next_o = sum[WIDTH-1:0];
                wrap_o = sum[WIDTH];
            end
            MODO_DOWN_STEP: begin
                sum    = {1'b0, q_i} - {1'b0, STEP_W};
                next_o = sum[WIDTH-1:0];
                wrap_o = sum[WIDTH];
            end
            MODO_UP_STEP: begin
                sum    = {1'b0, q_i} + {1'b0, STEP_W};
                next_o = sum[WIDTH-1:0];
                wrap_o = sum[WIDTH];
            end
            MODO_MOD: begin
                if (q_i >= limit_i) begin
                    next_o = '0;
                    wrap_o = 1'b1;
                end else begin
                    next_o = q_i + WIDTH'(1);
                end
            end
            default: begin
                // Load and hold: no count, never a wrap.
                next_o = q_i;
                wrap_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/contador_param.sv
// Parametrised counter/register: Q and RCO registers with reset, enable and
// carry-in qualification; TC is the unqualified wrap lookahead for cascading.
module contador_param
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STEP  = 3
) (
    input  logic             CLK,
    input  logic             RST_L,
    input  logic             ENB,
    input  logic             CI,
    input  logic [2:0]       MODO,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] LIMIT,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             TC
);

    logic [WIDTH-1:0] q_q;
    logic             rco_q;
    logic [WIDTH-1:0] next_q;
    logic             wrap;

    contador_paso #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_paso (
        .q_i     (q_q),
        .modo_i  (MODO),
        .limit_i (LIMIT),
        .next_o  (next_q),
        .wrap_o  (wrap)
    );

    // Load needs only ENB; counting modes also need CI. Hold modes fall
    // through the step logic as next=Q, wrap=0.
    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            q_q   <= WIDTH'(RESET_VALUE);
            rco_q <= 1'b0;
        end else begin
            rco_q <= 1'b0;
            if (ENB) begin
                if (MODO == MODO_LOAD) begin
                    q_q <= D;
                end else if (CI) begin
                    q_q   <= next_q;
                    rco_q <= wrap;
                end
            end
        end
    end

    assign Q   = q_q;
    assign RCO = rco_q;
    assign TC  = wrap;

endmodule

// File: tb/tb_contador_param.sv
// Scoreboard bench: stimulus pushes expected Q/RCO/TC, a negedge monitor pops and compares.
module tb_contador_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit instance
    logic       a_rst = 1'b0, a_enb = 1'b1, a_ci = 1'b1;
    logic [2:0] a_modo = 3'b000;
    logic [3:0] a_d = 4'h0, a_limit = 4'h0;
    logic [3:0] a_q;
    logic       a_rco, a_tc;

    // 16-bit instance
    logic        b_rst = 1'b0, b_enb = 1'b1, b_ci = 1'b1;
    logic [2:0]  b_modo = 3'b000;
    logic [15:0] b_d = 16'h0, b_limit = 16'h0;
    logic [15:0] b_q;
    logic        b_rco, b_tc;

    // Two cascaded 4-bit stages
    logic       c_rst = 1'b0;
    logic [3:0] lo_q, hi_q;
    logic       lo_rco, hi_rco, lo_tc, hi_tc;
    logic       hi_ci;
    assign hi_ci = lo_tc & 1'b1;

    contador_param #(.WIDTH(4), .STEP(3)) u_a (
        .CLK(clk), .RST_L(a_rst), .ENB(a_enb), .CI(a_ci), .MODO(a_modo),
        .D(a_d), .LIMIT(a_limit), .Q(a_q), .RCO(a_rco), .TC(a_tc)
    );

    contador_param #(.WIDTH(16), .STEP(3)) u_b (
        .CLK(clk), .RST_L(b_rst), .ENB(b_enb), .CI(b_ci), .MODO(b_modo),
        .D(b_d), .LIMIT(b_limit), .Q(b_q), .RCO(b_rco), .TC(b_tc)
    );

    contador_param #(.WIDTH(4), .STEP(3)) u_lo (
        .CLK(clk), .RST_L(c_rst), .ENB(1'b1), .CI(1'b1), .MODO(3'b000),
        .D(4'h0), .LIMIT(4'h0), .Q(lo_q), .RCO(lo_rco), .TC(lo_tc)
    );

    contador_param #(.WIDTH(4), .STEP(3)) u_hi (
        .CLK(clk), .RST_L(c_rst), .ENB(1'b1), .CI(hi_ci), .MODO(3'b000),
        .D(4'h0), .LIMIT(4'h0), .Q(hi_q), .RCO(hi_rco), .TC(hi_tc)
    );

    typedef struct {
        int unsigned dut;
        logic [15:0] q;
        logic        rco;
        logic        tc;
        bit          chk_tc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input string what,
                         input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    // Monitor: every output sample after an edge is matched to its queued expectation.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [15:0] aq;
        logic        ar, at;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin aq = 16'(a_q); ar = a_rco; at = a_tc; end
                1:       begin aq = b_q; ar = b_rco; at = b_tc; end
                default: begin aq = 16'({hi_q, lo_q}); ar = hi_rco; at = 1'b0; end
            endcase
            check(e.tag, "Q", aq, e.q);
            check(e.tag, "RCO", 16'(ar), 16'(e.rco));
            if (e.chk_tc) check(e.tag, "TC", 16'(at), 16'(e.tc));
        end
    end

    task automatic push(input int unsigned dut, input string tag, input logic [15:0] q,
                        input logic rco, input logic tc, input bit chk_tc);
        exp_t e;
        e.dut = dut; e.tag = tag; e.q = q; e.rco = rco; e.tc = tc; e.chk_tc = chk_tc;
        sb.push_back(e);
    endtask

    task automatic step_a(input string tag, input logic rst, input logic enb, input logic ci,
                          input logic [2:0] modo, input logic [3:0] d, input logic [3:0] limit,
                          input logic [3:0] eq, input logic er, input logic et);
        @(negedge clk); #1;
        a_rst = rst; a_enb = enb; a_ci = ci; a_modo = modo; a_d = d; a_limit = limit;
        push(0, tag, 16'(eq), er, et, 1'b1);
    endtask

    task automatic step_b(input string tag, input logic rst, input logic [2:0] modo,
                          input logic [15:0] d, input logic [15:0] limit,
                          input logic [15:0] eq, input logic er, input logic et);
        @(negedge clk); #1;
        b_rst = rst; b_enb = 1'b1; b_ci = 1'b1; b_modo = modo; b_d = d; b_limit = limit;
        push(1, tag, eq, er, et, 1'b1);
    endtask

    task automatic step_c(input string tag, input logic rst, input logic [7:0] eq,
                          input logic er);
        @(negedge clk); #1;
        c_rst = rst;
        push(2, tag, 16'(eq), er, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset, load 0, count up through the wrap
        step_a("a_rst0", 0, 1, 1, 3'b000, 4'h0, 4'h0, 4'h0, 0, 0);
        step_a("a_rst1", 0, 1, 1, 3'b000, 4'h0, 4'h0, 4'h0, 0, 0);
        step_a("a_ld0",  1, 1, 1, 3'b011, 4'h0, 4'h0, 4'h0, 0, 0);
        for (int i = 1; i <= 16; i++)
            step_a("a_up", 1, 1, 1, 3'b000, 4'h0, 4'h0, 4'(i), i == 16, i == 15);

        // Down by 1 from F, then down by STEP
        step_a("a_ldF", 1, 1, 1, 3'b011, 4'hF, 4'h0, 4'hF, 0, 0);
        for (int i = 1; i <= 16; i++)
            step_a("a_dn", 1, 1, 1, 3'b001, 4'h0, 4'h0, 4'(15 - i), i == 16, i == 15);
        step_a("a_ds", 1, 1, 1, 3'b010, 4'h0, 4'h0, 4'hC, 0, 0);
        step_a("a_ds", 1, 1, 1, 3'b010, 4'h0, 4'h0, 4'h9, 0, 0);
        step_a("a_ds", 1, 1, 1, 3'b010, 4'h0, 4'h0, 4'h6, 0, 0);
        step_a("a_ds", 1, 1, 1, 3'b010, 4'h0, 4'h0, 4'h3, 0, 0);
        step_a("a_ds", 1, 1, 1, 3'b010, 4'h0, 4'h0, 4'h0, 0, 1);
        step_a("a_ds", 1, 1, 1, 3'b010, 4'h0, 4'h0, 4'hD, 1, 0);

        // Enable / carry-in qualification; load ignores CI
        step_a("a_ld6",   1, 1, 1, 3'b011, 4'h6, 4'h0, 4'h6, 0, 0);
        step_a("a_to7",   1, 1, 1, 3'b000, 4'h0, 4'h0, 4'h7, 0, 0);
        step_a("a_enb0",  1, 0, 1, 3'b000, 4'h0, 4'h0, 4'h7, 0, 0);
        step_a("a_ci0",   1, 1, 0, 3'b000, 4'h0, 4'h0, 4'h7, 0, 0);
        step_a("a_ci0ld", 1, 1, 0, 3'b011, 4'h9, 4'h0, 4'h9, 0, 0);
        step_a("a_ldF2",  1, 1, 1, 3'b011, 4'hF, 4'h0, 4'hF, 0, 0);
        step_a("a_tcci0", 1, 1, 0, 3'b000, 4'h0, 4'h0, 4'hF, 0, 1);
        step_a("a_tcenb", 1, 0, 1, 3'b000, 4'h0, 4'h0, 4'hF, 0, 1);

        // Reset priority over a pending wrap and over a load
        step_a("a_rstwr", 0, 1, 1, 3'b000, 4'h0, 4'h0, 4'h0, 0, 0);
        step_a("a_ld9",   1, 1, 1, 3'b011, 4'h9, 4'h0, 4'h9, 0, 0);
        step_a("a_toA",   1, 1, 1, 3'b000, 4'h0, 4'h0, 4'hA, 0, 0);
        step_a("a_rstld", 0, 1, 1, 3'b011, 4'h3, 4'h0, 4'h0, 0, 0);
        step_a("a_rel",   1, 1, 1, 3'b011, 4'h3, 4'h0, 4'h3, 0, 0);
        step_a("a_h110",  1, 1, 1, 3'b110, 4'h0, 4'h0, 4'h3, 0, 0);
        step_a("a_h111",  1, 1, 1, 3'b111, 4'h0, 4'h0, 4'h3, 0, 0);
        step_a("a_rstdn", 0, 1, 1, 3'b001, 4'h0, 4'h0, 4'h0, 0, 1);
        // LIMIT=0 modulo: wraps every qualified cycle
        step_a("a_lim0",  1, 1, 1, 3'b101, 4'h0, 4'h0, 4'h0, 1, 1);
        step_a("a_lim0",  1, 1, 1, 3'b101, 4'h0, 4'h0, 4'h0, 1, 1);

        // 16-bit: up by STEP carry, modulo with a limit change mid-count
        step_b("b_rst",   0, 3'b000, 16'h0000, 16'h0, 16'h0000, 0, 0);
        step_b("b_rst",   0, 3'b000, 16'h0000, 16'h0, 16'h0000, 0, 0);
        step_b("b_ld",    1, 3'b011, 16'hFFFD, 16'h0, 16'hFFFD, 0, 0);
        step_b("b_us",    1, 3'b100, 16'h0000, 16'h0, 16'h0000, 1, 0);
        step_b("b_ld2",   1, 3'b011, 16'hFFFB, 16'h0, 16'hFFFB, 0, 0);
        step_b("b_us2",   1, 3'b100, 16'h0000, 16'h0, 16'hFFFE, 0, 1);
        step_b("b_us3",   1, 3'b100, 16'h0000, 16'h0, 16'h0001, 1, 0);
        step_b("b_ld0",   1, 3'b011, 16'h0000, 16'h5, 16'h0000, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            int v;
            v = (i <= 5) ? i : i - 6;
            step_b("b_mod", 1, 3'b101, 16'h0000, 16'h5, 16'(v), i == 6, v == 5);
        end
        step_b("b_lim2",  1, 3'b101, 16'h0000, 16'h2, 16'h0000, 1, 0);

        // Cascade of two 4-bit stages through TC/CI
        step_c("c_rst", 0, 8'h00, 0);
        step_c("c_rst", 0, 8'h00, 0);
        for (int i = 1; i <= 256; i++)
            step_c("c_cnt", 1, 8'(i), i == 256);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
